// File: rtl/if_fetch_pc_unit.sv
// rtl/if_fetch_pc_unit.sv - fetch-stage PC generator with BTB gating, direction counters and IF/ID register
//
// Purpose: produces the fetch PC each cycle, qualifies BTB hits with a table of
// 2-bit saturating direction counters, redirects fetch on mispredictions resolved
// in EX, and carries PC plus prediction metadata into ID.
//
// Optional feature macro: PRED_STATS_EN (adds stat_branches / stat_mispredicts).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall_if            hazard stall; holds pc_if and IF/ID
//   btb_hit, btb_target BTB lookup result for pc_if
//   ex_*                resolved branch information from EX
//   pc_if               current fetch PC to BTB and instruction memory
//   id_valid, id_pc,
//   id_pred_taken,
//   id_pred_target      IF/ID pipeline register
//   redirect            combinational mispredict flag; flushes IF/ID and ID/EX
//   stat_branches,
//   stat_mispredicts    branch / mispredict counters (PRED_STATS_EN only)

module if_fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IDX_W    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        btb_hit,
    input  logic [31:0] btb_target,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic [31:0] pc_if,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic        id_pred_taken,
    output logic [31:0] id_pred_target,
    output logic        redirect
`ifdef PRED_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int NUM_CTR = 1 << IDX_W;

    logic [1:0]       ctr [NUM_CTR];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       cnt;
    logic             pred_taken;
    logic [31:0]      pc_plus4;
    logic [31:0]      pred_next;
    logic             mispredict;
    logic [31:0]      fix_pc;

    assign rd_idx = pc_if[IDX_W+1:2];
    assign wr_idx = ex_pc[IDX_W+1:2];

    // Read sees the pre-update value when EX writes the same entry this cycle.
    assign cnt        = ctr[rd_idx];
    assign pred_taken = btb_hit & cnt[1];
    assign pc_plus4   = pc_if + 32'd4;
    assign pred_next  = pred_taken ? btb_target : pc_plus4;

    // A taken branch with the right direction can still mispredict on target.
    assign mispredict = ex_is_branch &
                        ((ex_taken != ex_pred_taken) |
                         (ex_taken & (ex_target != ex_pred_target)));
    assign redirect   = mispredict;
    assign fix_pc     = ex_taken ? ex_target : (ex_pc + 32'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_if <= RESET_PC;
        end else if (mispredict) begin
            pc_if <= fix_pc;
        end else if (!stall_if) begin
            pc_if <= pred_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || mispredict) begin
            id_valid       <= 1'b0;
            id_pc          <= 32'd0;
            id_pred_taken  <= 1'b0;
            id_pred_target <= 32'd0;
        end else if (!stall_if) begin
            id_valid       <= 1'b1;
            id_pc          <= pc_if;
            id_pred_taken  <= pred_taken;
            id_pred_target <= pred_next;
        end
    end

    // Training follows EX regardless of fetch stalls; saturating, no wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CTR; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (ex_is_branch) begin
            if (ex_taken) begin
                if (ctr[wr_idx] != 2'b11) begin
                    ctr[wr_idx] <= ctr[wr_idx] + 2'b01;
                end
            end else begin
                if (ctr[wr_idx] != 2'b00) begin
                    ctr[wr_idx] <= ctr[wr_idx] - 2'b01;
                end
            end
        end
    end

`ifdef PRED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (ex_is_branch) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_pc_unit.sv
// tb/tb_if_fetch_pc_unit.sv - directed self-checking bench for if_fetch_pc_unit

module tb_if_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_if;
    logic        btb_hit;
    logic [31:0] btb_target;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] pc_if;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;
    logic        redirect;
`ifdef PRED_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_br   = 0;
    int exp_misp = 0;

    always #5 clk = ~clk;

    if_fetch_pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall_if      (stall_if),
        .btb_hit       (btb_hit),
        .btb_target    (btb_target),
        .ex_is_branch  (ex_is_branch),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .ex_pred_taken (ex_pred_taken),
        .ex_pred_target(ex_pred_target),
        .pc_if         (pc_if),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_pred_taken (id_pred_taken),
        .id_pred_target(id_pred_target),
        .redirect      (redirect)
`ifdef PRED_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    // Reference counts of branches and mispredicts derived from driven inputs.
    always @(posedge clk) begin
        if (rst) begin
            exp_br   <= 0;
            exp_misp <= 0;
        end else if (ex_is_branch) begin
            exp_br <= exp_br + 1;
            if ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target))
                exp_misp <= exp_misp + 1;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex;
        ex_is_branch   = 1'b0;
        ex_pc          = 32'd0;
        ex_taken       = 1'b0;
        ex_target      = 32'd0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = 32'd0;
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Steer fetch to addr via a mispredicted jump from 0x200 (counter index 0).
    task automatic jump(input logic [31:0] addr);
        ex_is_branch  = 1'b1;
        ex_pc         = 32'h200;
        ex_taken      = 1'b1;
        ex_target     = addr;
        ex_pred_taken = 1'b0;
        step();
        clear_ex();
    endtask

    // Non-mispredicting EX update of the counter indexed by pc.
    task automatic train(input logic [31:0] pc, input logic taken);
        ex_is_branch   = 1'b1;
        ex_pc          = pc;
        ex_taken       = taken;
        ex_pred_taken  = taken;
        ex_target      = 32'h500;
        ex_pred_target = 32'h500;
        #1;
        chk32("train_no_redirect", {31'd0, redirect}, 32'd0);
        step();
        clear_ex();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        chk32("rst_pc_if", pc_if, 32'h0);
        chk32("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk32("rst_id_pc", id_pc, 32'h0);
        chk32("rst_id_pred_taken", {31'd0, id_pred_taken}, 32'd0);
        chk32("rst_id_pred_target", id_pred_target, 32'h0);
        chk32("rst_redirect", {31'd0, redirect}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic test_free_run;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk32("run_pc_if", pc_if, 32'(4 * i));
            chk32("run_id_valid", {31'd0, id_valid}, 32'd1);
            chk32("run_id_pc", id_pc, 32'(4 * (i - 1)));
        end
    endtask

    task automatic test_weak_hit;
        jump(32'h10);
        chk32("weak_jump_pc", pc_if, 32'h10);
        chk32("weak_jump_flush", {31'd0, id_valid}, 32'd0);
        btb_hit    = 1'b1;
        btb_target = 32'h40;
        step();
        btb_hit = 1'b0;
        chk32("weak_pc_if", pc_if, 32'h14);
        chk32("weak_id_pc", id_pc, 32'h10);
        chk32("weak_id_pred_taken", {31'd0, id_pred_taken}, 32'd0);
        chk32("weak_id_pred_target", id_pred_target, 32'h14);
    endtask

    task automatic test_train_taken;
        train(32'h10, 1'b1);
        train(32'h10, 1'b1);
        jump(32'h10);
        btb_hit    = 1'b1;
        btb_target = 32'h40;
        step();
        btb_hit = 1'b0;
        chk32("train_pc_if", pc_if, 32'h40);
        chk32("train_id_valid", {31'd0, id_valid}, 32'd1);
        chk32("train_id_pred_taken", {31'd0, id_pred_taken}, 32'd1);
        chk32("train_id_pred_target", id_pred_target, 32'h40);
    endtask

    task automatic test_mispredict_stall;
        stall_if      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_pc         = 32'h20;
        ex_taken      = 1'b1;
        ex_target     = 32'h80;
        ex_pred_taken = 1'b0;
        #1;
        chk32("stall_redirect", {31'd0, redirect}, 32'd1);
        step();
        clear_ex();
        chk32("stall_pc_if", pc_if, 32'h80);
        chk32("stall_id_valid", {31'd0, id_valid}, 32'd0);
        step();
        chk32("stall_hold_pc", pc_if, 32'h80);
        chk32("stall_hold_valid", {31'd0, id_valid}, 32'd0);
        stall_if = 1'b0;
        step();
        chk32("stall_release_pc", pc_if, 32'h84);
        chk32("stall_release_id_pc", id_pc, 32'h80);
    endtask

    task automatic test_wrong_target;
        ex_is_branch   = 1'b1;
        ex_pc          = 32'h50;
        ex_taken       = 1'b1;
        ex_pred_taken  = 1'b1;
        ex_target      = 32'h100;
        ex_pred_target = 32'h104;
        #1;
        chk32("tgt_redirect", {31'd0, redirect}, 32'd1);
        step();
        chk32("tgt_pc_if", pc_if, 32'h100);
        ex_pc          = 32'h30;
        ex_taken       = 1'b0;
        ex_pred_taken  = 1'b1;
        ex_target      = 32'h0;
        ex_pred_target = 32'h60;
        #1;
        chk32("nt_redirect", {31'd0, redirect}, 32'd1);
        step();
        clear_ex();
        chk32("nt_pc_if", pc_if, 32'h34);
        chk32("nt_id_valid", {31'd0, id_valid}, 32'd0);
    endtask

    task automatic test_saturation;
        // Index 15: 01 -> 00 -> 00 -> 00, then one taken -> 01 (not taken).
        train(32'h3C, 1'b0);
        train(32'h3C, 1'b0);
        train(32'h3C, 1'b0);
        train(32'h3C, 1'b1);
        jump(32'h3C);
        btb_hit    = 1'b1;
        btb_target = 32'h90;
        step();
        btb_hit = 1'b0;
        chk32("sat_low_pc_if", pc_if, 32'h40);
        // Index 4 is 11: two more taken stay at 11, one not-taken -> 10 (taken).
        train(32'h10, 1'b1);
        train(32'h10, 1'b1);
        train(32'h10, 1'b0);
        jump(32'h10);
        btb_hit    = 1'b1;
        btb_target = 32'h40;
        step();
        btb_hit = 1'b0;
        chk32("sat_high_pc_if", pc_if, 32'h40);
    endtask

    task automatic test_pc_wrap;
        jump(32'hFFFF_FFFC);
        step();
        chk32("wrap_pc_if", pc_if, 32'h0);
        chk32("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        chk32("wrap_id_pred_target", id_pred_target, 32'h0);
    endtask

    task automatic test_stats;
`ifdef PRED_STATS_EN
        chk32("stat_branches", stat_branches, 32'(exp_br));
        chk32("stat_mispredicts", stat_mispredicts, 32'(exp_misp));
`endif
    endtask

    task automatic test_reset_priority;
        ex_is_branch  = 1'b1;
        ex_pc         = 32'h20;
        ex_taken      = 1'b1;
        ex_target     = 32'h80;
        ex_pred_taken = 1'b0;
        rst           = 1'b1;
        step();
        rst = 1'b0;
        clear_ex();
        chk32("rstpri_pc_if", pc_if, 32'h0);
        chk32("rstpri_id_valid", {31'd0, id_valid}, 32'd0);
`ifdef PRED_STATS_EN
        chk32("rstpri_stat_mispredicts", stat_mispredicts, 32'd0);
`endif
        // Counters back at 01: a BTB hit at 0x10 is not followed.
        jump(32'h10);
        btb_hit    = 1'b1;
        btb_target = 32'h40;
        step();
        btb_hit = 1'b0;
        chk32("rstpri_ctr_pc_if", pc_if, 32'h14);
    endtask

    initial begin
        rst        = 1'b0;
        stall_if   = 1'b0;
        btb_hit    = 1'b0;
        btb_target = 32'h0;
        clear_ex();
        #2;
        test_reset();
        test_free_run();
        test_weak_hit();
        test_train_taken();
        test_mispredict_stall();
        test_wrong_target();
        test_saturation();
        test_pc_wrap();
        test_stats();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
